// File: rtl/muldiv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : muldiv_seq
//  Purpose  : Iterative signed multiply/divide sequencer owning HI/LO.
//             32-step radix-2 Booth multiply or 32-step restoring divide on
//             operand magnitudes, followed by a one-cycle sign-fix stage.
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic        divzero,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] c_IDLE      = 2'd0;
    localparam logic [1:0] c_MULT      = 2'd1;
    localparam logic [1:0] c_DIV       = 2'd2;
    localparam logic [1:0] c_FIX       = 2'd3;
    localparam logic [4:0] c_LAST_STEP = 5'd31;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic        r_is_div;
    // Booth multiply datapath: {r_acc, r_q, r_qm1} plus the multiplicand
    logic [31:0] r_mcand;
    logic [31:0] r_acc;
    logic [31:0] r_q;
    logic        r_qm1;
    // Restoring divide datapath on magnitudes
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_dvs;
    logic        r_neg_q;
    logic        r_neg_r;
    // Architectural results and pulses
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_divzero;

    logic [32:0] w_booth_sum;
    logic [32:0] w_rem_sh;
    logic [33:0] w_trial;
    logic        w_fits;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    // Step arithmetic: Booth add/sub uses a 33-bit sum so that subtracting
    // the most negative multiplicand cannot overflow before the shift.
    always_comb begin
        w_booth_sum = {r_acc[31], r_acc};
        case ({r_q[0], r_qm1})
            2'b01:   w_booth_sum = {r_acc[31], r_acc} + {r_mcand[31], r_mcand};
            2'b10:   w_booth_sum = {r_acc[31], r_acc} - {r_mcand[31], r_mcand};
            default: w_booth_sum = {r_acc[31], r_acc};
        endcase
        w_rem_sh  = {r_rem, r_quo[31]};
        w_trial   = {1'b0, w_rem_sh} - {2'b00, r_dvs};
        w_fits    = ~w_trial[33];
        // |-2^31| = 0x80000000 is representable as an unsigned 32-bit value
        w_abs_a   = a[31] ? (32'd0 - a) : a;
        w_abs_b   = b[31] ? (32'd0 - b) : b;
        w_quo_fix = r_neg_q ? (32'd0 - r_quo) : r_quo;
        w_rem_fix = r_neg_r ? (32'd0 - r_rem) : r_rem;
    end

    // Control FSM and datapath registers; hi/lo only change in FIX or reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= c_IDLE;
            r_cnt     <= 5'd0;
            r_is_div  <= 1'b0;
            r_mcand   <= 32'd0;
            r_acc     <= 32'd0;
            r_q       <= 32'd0;
            r_qm1     <= 1'b0;
            r_rem     <= 32'd0;
            r_quo     <= 32'd0;
            r_dvs     <= 32'd0;
            r_neg_q   <= 1'b0;
            r_neg_r   <= 1'b0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_divzero <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (start_mult) begin
                        r_mcand  <= a;
                        r_acc    <= 32'd0;
                        r_q      <= b;
                        r_qm1    <= 1'b0;
                        r_is_div <= 1'b0;
                        r_cnt    <= 5'd0;
                        r_state  <= c_MULT;
                    end else if (start_div) begin
                        if (b == 32'd0) begin
                            r_divzero <= 1'b1;
                        end else begin
                            r_dvs    <= w_abs_b;
                            r_quo    <= w_abs_a;
                            r_rem    <= 32'd0;
                            r_neg_q  <= a[31] ^ b[31];
                            r_neg_r  <= a[31];
                            r_is_div <= 1'b1;
                            r_cnt    <= 5'd0;
                            r_state  <= c_DIV;
                        end
                    end
                end
                c_MULT: begin
                    r_acc <= w_booth_sum[32:1];
                    r_q   <= {w_booth_sum[0], r_q[31:1]};
                    r_qm1 <= r_q[0];
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_LAST_STEP) r_state <= c_FIX;
                end
                c_DIV: begin
                    // A failed trial means rem_sh < divisor <= 2^31, so its
                    // top bit is zero and the low 32 bits are the restore.
                    r_rem <= w_fits ? w_trial[31:0] : w_rem_sh[31:0];
                    r_quo <= {r_quo[30:0], w_fits};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_LAST_STEP) r_state <= c_FIX;
                end
                c_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end else begin
                        r_hi <= r_acc;
                        r_lo <= r_q;
                    end
                    r_done  <= 1'b1;
                    r_state <= c_IDLE;
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    assign busy    = (r_state != c_IDLE);
    assign done    = r_done;
    assign divzero = r_divzero;
    assign hi      = r_hi;
    assign lo      = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_seq
//  Purpose  : Self-checking bench for muldiv_seq with a 64-bit arithmetic
//             reference model and randomized operands.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic        divzero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    muldiv_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .divzero    (divzero),
        .hi         (hi),
        .lo         (lo)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Reference: signed 64-bit product, or truncating quotient/remainder.
    function automatic logic [63:0] ref_op(input bit is_div, input logic [31:0] x,
                                           input logic [31:0] y);
        longint sx, sy, q, r;
        logic [63:0] res;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        if (!is_div) begin
            res = sx * sy;
        end else begin
            q   = sx / sy;
            r   = sx % sy;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    // Issue one operation from a negedge; returns at the negedge where done
    // is seen (edges = 33 for the nominal latency) or after a bound.
    task automatic do_op(input bit is_div, input logic [31:0] x, input logic [31:0] y,
                         output int edges, output bit busy_e0);
        a = x;
        b = y;
        start_mult = !is_div;
        start_div  = is_div;
        @(posedge clk);
        @(negedge clk);
        start_mult = 1'b0;
        start_div  = 1'b0;
        busy_e0 = (busy === 1'b1);
        edges = 0;
        while (done !== 1'b1 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start_mult = 1'b0; start_div = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({busy, done, divzero, hi, lo} !== 67'd0) begin
            bad++;
            $display("FAIL reset_state got=%h exp=0", {busy, done, divzero, hi, lo});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult_directed();
        logic [31:0] xa[3] = '{32'd7, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] xb[3] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF};
        logic [63:0] ex[3] = '{64'hFFFFFFFF_FFFFFFEB, 64'h40000000_00000000, 64'h00000000_00000001};
        int e; bit be;
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, xa[i], xb[i], e, be);
            total++;
            if ({hi, lo} !== ex[i]) begin
                bad++; $display("FAIL mult_dir[%0d] got=%h exp=%h", i, {hi, lo}, ex[i]);
            end
            total++;
            if (e != 33 || !be || busy !== 1'b0) begin
                bad++; $display("FAIL mult_timing[%0d] edges=%0d busy_e0=%0d busy_done=%b exp=33/1/0", i, e, be, busy);
            end
            @(negedge clk);
            total++;
            if (done !== 1'b0) begin
                bad++; $display("FAIL done_pulse[%0d] got=%b exp=0", i, done);
            end
        end
    endtask

    task automatic test_div_directed();
        logic [31:0] xa[3] = '{32'hFFFFFFF9, 32'd7, 32'h80000000};
        logic [31:0] xb[3] = '{32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF};
        logic [63:0] ex[3] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD, 64'h00000000_80000000};
        int e; bit be;
        for (int i = 0; i < 3; i++) begin
            do_op(1'b1, xa[i], xb[i], e, be);
            total++;
            if ({hi, lo} !== ex[i] || e != 33 || !be) begin
                bad++; $display("FAIL div_dir[%0d] got=%h edges=%0d exp=%h edges=33", i, {hi, lo}, e, ex[i]);
            end
        end
    endtask

    task automatic test_divzero();
        int e; bit be; bit seen;
        logic [63:0] keep;
        do_op(1'b0, 32'h1234, 32'h5678, e, be);
        keep = {hi, lo};
        a = 32'd5; b = 32'd0; start_div = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_div = 1'b0;
        total++;
        if (divzero !== 1'b1 || busy !== 1'b0) begin
            bad++; $display("FAIL divzero_pulse got dz=%b busy=%b exp dz=1 busy=0", divzero, busy);
        end
        @(negedge clk);
        total++;
        if (divzero !== 1'b0) begin
            bad++; $display("FAIL divzero_width got=%b exp=0", divzero);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0 || divzero !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen || {hi, lo} !== keep) begin
            bad++; $display("FAIL divzero_quiet activity=%b hilo=%h exp activity=0 hilo=%h", seen, {hi, lo}, keep);
        end
    endtask

    task automatic test_both_starts();
        int e; bit seen;
        a = 32'd3; b = 32'd4; start_mult = 1'b1; start_div = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_mult = 1'b0; start_div = 1'b0;
        repeat (4) @(negedge clk);
        a = 32'd100; b = 32'd1; start_div = 1'b1;
        @(negedge clk);
        start_div = 1'b0;
        e = 5;
        while (done !== 1'b1 && e < 100) begin
            @(negedge clk);
            e++;
        end
        total++;
        if ({hi, lo} !== 64'd12 || e != 33) begin
            bad++; $display("FAIL both_starts got=%h edges=%0d exp=%h edges=33", {hi, lo}, e, 64'd12);
        end
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
        end
        total++;
        if (seen) begin
            bad++; $display("FAIL busy_start_ignored got=extra_activity exp=none");
        end
    endtask

    task automatic test_async_reset();
        int e; bit be;
        do_op(1'b0, 32'd5, 32'd7, e, be);
        a = 32'h12345678; b = 32'h9ABCDEF0; start_mult = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_mult = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if ({busy, done, divzero, hi, lo} !== 67'd0) begin
            bad++; $display("FAIL async_reset got=%h exp=0", {busy, done, divzero, hi, lo});
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        do_op(1'b0, 32'd2, 32'd3, e, be);
        total++;
        if ({hi, lo} !== 64'd6 || e != 33) begin
            bad++; $display("FAIL post_reset_mult got=%h edges=%0d exp=%h edges=33", {hi, lo}, e, 64'd6);
        end
    endtask

    task automatic test_random();
        logic [31:0] specials[6] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h80000001};
        logic [31:0] x, y;
        logic [63:0] ex;
        bit d; int e; bit be;
        for (int i = 0; i < 30; i++) begin
            d = $urandom_range(0, 1);
            x = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if (d && y == 32'd0) y = 32'd3;
            ex = ref_op(d, x, y);
            do_op(d, x, y, e, be);
            total++;
            if ({hi, lo} !== ex || e != 33) begin
                bad++; $display("FAIL random[%0d] div=%0d a=%h b=%h got=%h edges=%0d exp=%h", i, d, x, y, {hi, lo}, e, ex);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] x, y;
        logic [63:0] ex;
        int e; bit be;
        int t0, t1;
        for (int i = 0; i < 4; i++) begin
            x = $urandom;
            y = $urandom | 32'd1;
            ex = ref_op(i[0], x, y);
            t0 = $time;
            do_op(i[0], x, y, e, be);
            t1 = $time;
            total++;
            if ({hi, lo} !== ex || (t1 - t0) != 340) begin
                bad++; $display("FAIL back_to_back[%0d] got=%h period=%0d exp=%h period=340", i, {hi, lo}, t1 - t0, ex);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mult_directed();
        test_div_directed();
        test_divzero();
        test_both_starts();
        test_async_reset();
        test_random();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
